// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Bits needed to index value distinct items; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of valid at or after start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   start,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // Explicit modulo wrap so non-power-of-two NREQ works.
            pos = {1'b0, start} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(NREQ)) begin
                pos = pos - (IW + 1)'(NREQ);
            end
            if (!any && valid[pos[IW-1:0]]) begin
                any                 = 1'b1;
                idx                 = pos[IW-1:0];
                onehot[pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding the LED-frame FIFO write port through a one-entry output stage.
// Packet locking is compiled in with FIFO_ARB_PKT_LOCK_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_n,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [DSIZE-1:0]        fifo_wr_data,
    output logic                    fifo_wr_valid,
    input  logic                    fifo_wr_ready,
    output logic [clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned IW = clog2(NREQ);

    logic              out_valid;
    logic [DSIZE-1:0]  out_data;
    logic [IW-1:0]     last_grant;

    logic [NREQ-1:0]   pick_mask;
    logic [IW-1:0]     start_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic [DSIZE-1:0]  win_data;
    logic              can_load;
    logic              accept;

`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam int unsigned BCW = clog2(MAX_BURST + 1);

    arb_state_e        state;
    logic [BCW-1:0]    beat_cnt;
    logic [BCW-1:0]    cnt_next;
    logic              win_last;

    // While locked only the held requester is visible to the picker.
    assign pick_mask = (state == LOCK) ? (req_valid & (NREQ'(1) << last_grant)) : req_valid;
    assign win_last  = |(req_last & win_onehot);
    assign cnt_next  = (beat_cnt == BCW'(MAX_BURST)) ? beat_cnt : beat_cnt + BCW'(1);
`else
    logic              unused_last;

    assign pick_mask   = req_valid;
    assign unused_last = ^{req_last, (MAX_BURST > 32'd0)};
`endif

    assign start_idx = (last_grant == IW'(NREQ - 1)) ? '0 : last_grant + IW'(1);

    rr_pick #(
        .NREQ   (NREQ)
    ) u_pick (
        .valid  (pick_mask),
        .start  (start_idx),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // Winner data mux driven by the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_data = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign can_load  = !out_valid || fifo_wr_ready;
    assign accept    = win_any && can_load && clear_n && rst_n;
    assign req_ready = accept ? win_onehot : '0;

    assign fifo_wr_valid = out_valid;
    assign fifo_wr_data  = out_data;
    assign grant_id      = last_grant;

    // Output stage, grant pointer and packet-lock state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= IW'(NREQ - 1);
`ifdef FIFO_ARB_PKT_LOCK_EN
            state      <= ARB;
            beat_cnt   <= '0;
`endif
        end else if (!clear_n) begin
            out_valid  <= 1'b0;
`ifdef FIFO_ARB_PKT_LOCK_EN
            state      <= ARB;
            beat_cnt   <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_data   <= win_data;
                last_grant <= win_idx;
            end else if (fifo_wr_ready) begin
                out_valid  <= 1'b0;
            end
`ifdef FIFO_ARB_PKT_LOCK_EN
            if (accept) begin
                case (state)
                    ARB: begin
                        if (!win_last && (MAX_BURST > 32'd1)) begin
                            state    <= LOCK;
                            beat_cnt <= BCW'(1);
                        end
                    end
                    LOCK: begin
                        // Leave on end of packet or when the burst budget is spent.
                        if (win_last || (cnt_next == BCW'(MAX_BURST))) begin
                            state    <= ARB;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= cnt_next;
                        end
                    end
                    default: begin
                        state    <= ARB;
                        beat_cnt <= '0;
                    end
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; lock scenarios run when FIFO_ARB_PKT_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned DSIZE     = 32;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned IW        = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clear_n;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [DSIZE-1:0]      fifo_wr_data;
    logic                  fifo_wr_valid;
    logic                  fifo_wr_ready;
    logic [IW-1:0]         grant_id;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_n       (clear_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_valid (fifo_wr_valid),
        .fifo_wr_ready (fifo_wr_ready),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] pend_data[NREQ][$];
    bit               pend_last[NREQ][$];
    logic [DSIZE-1:0] sb[$];
    int               got_ids[$];
    int               exp_ids[$];
    int               seq = 0;

    bit want_rst = 1'b0, want_clr = 1'b1, want_rdy = 1'b1, flush_sb = 1'b0;
    logic [NREQ-1:0] acc_mask = '0;
    logic [NREQ-1:0] dut_rdy  = '0;

    // Reference model state: pointer, output-stage occupancy, packet lock.
    int m_last = NREQ - 1;
    bit m_ov   = 1'b0;
    bit m_lock = 1'b0;
    int m_lid  = 0;
    int m_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_beat(input int i, input bit last);
        pend_data[i].push_back({8'(i), 24'(seq)});
        pend_last[i].push_back(last);
        seq++;
    endtask

    task automatic model_eval();
        int w;
        logic [NREQ-1:0] exp;
        w   = -1;
        exp = '0;
        if (rst_n && clear_n && (!m_ov || fifo_wr_ready)) begin
            if (m_lock) begin
                if (req_valid[m_lid]) w = m_lid;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_last + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
        end
        if (w >= 0) exp[w] = 1'b1;
        dut_rdy = req_ready;
        chk("req_ready", req_ready, exp);
        chk("grant_id", grant_id, 64'(m_last));
        chk("wr_valid", fifo_wr_valid, m_ov);
        acc_mask = exp;
        if (!rst_n) begin
            m_ov = 0; m_last = NREQ - 1; m_lock = 0; m_cnt = 0; flush_sb = 1;
        end else if (!clear_n) begin
            m_ov = 0; m_lock = 0; m_cnt = 0; flush_sb = 1;
        end else if (w >= 0) begin
            sb.push_back(req_data[w*DSIZE +: DSIZE]);
            m_ov   = 1;
            m_last = w;
`ifdef FIFO_ARB_PKT_LOCK_EN
            if (!m_lock) begin
                if (!req_last[w] && MAX_BURST > 1) begin
                    m_lock = 1; m_lid = w; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (req_last[w] || m_cnt >= MAX_BURST) begin
                    m_lock = 0; m_cnt = 0;
                end
            end
`endif
        end else if (fifo_wr_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (flush_sb) begin
            sb.delete();
            flush_sb = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && pend_data[i].size() > 0) begin
                req_data[i*DSIZE +: DSIZE] = pend_data[i].pop_front();
                req_last[i]  = pend_last[i].pop_front();
                req_valid[i] = 1'b1;
            end
        end
        rst_n         = want_rst;
        clear_n       = want_clr;
        fifo_wr_ready = want_rdy;
        #1;
        model_eval();
    endtask

    task automatic drain(input string name);
        int n;
        bit busy;
        want_rdy = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            busy = (sb.size() != 0) || (req_valid != '0);
            for (int i = 0; i < NREQ; i++) if (pend_data[i].size() != 0) busy = 1'b1;
        end while (busy && n < 300);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic chk_ids(input string name);
        chk({name, "_count"}, 64'(got_ids.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++)
            chk(name, 64'(got_ids[i]), 64'(exp_ids[i]));
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks hold stability.
    initial begin : monitor
        logic             hold;
        logic [DSIZE-1:0] hold_data;
        logic [DSIZE-1:0] e;
        hold      = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", fifo_wr_valid, 1'b1);
                chk("hold_data", fifo_wr_data, hold_data);
            end
            if (fifo_wr_valid === 1'b1 && fifo_wr_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected no write", fifo_wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("write_data", fifo_wr_data, e);
                    got_ids.push_back(int'(fifo_wr_data[DSIZE-1 -: 8]));
                end
            end
            hold      = (fifo_wr_valid === 1'b1) && (fifo_wr_ready === 1'b0) && rst_n && clear_n;
            hold_data = fifo_wr_data;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int busy_cycles;
        rst_n = 1'b0; clear_n = 1'b1; fifo_wr_ready = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;

        // Reset and reset values.
        want_rst = 1'b0;
        step(); step();
        want_rst = 1'b1;
        step();
        chk("rst_wr_valid", fifo_wr_valid, 1'b0);
        chk("rst_wr_data", fifo_wr_data, 32'h0);
        chk("rst_grant_id", grant_id, 2'd3);
        chk("rst_req_ready", req_ready, 4'h0);

        // All valid: rotation 0,1,2,3,0 at one beat per cycle.
        add_beat(0, 1); add_beat(1, 1); add_beat(2, 1); add_beat(3, 1); add_beat(0, 1);
        got_ids.delete();
        busy_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (dut_rdy != '0) busy_cycles++;
        end
        chk("rotation_throughput", 64'(busy_cycles), 64'd5);
        drain("rotation");
        exp_ids.delete();
        exp_ids.push_back(0); exp_ids.push_back(1); exp_ids.push_back(2);
        exp_ids.push_back(3); exp_ids.push_back(0);
        chk_ids("rotation_order");

        // Backpressure: hold for 5 cycles with a beat in the output stage.
        for (int i = 0; i < NREQ; i++) add_beat(i, 1);
        want_rdy = 1'b1;
        step();
        want_rdy = 1'b0;
        repeat (5) step();
        drain("backpressure");

        // Randomized traffic with backpressure and occasional clears.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (pend_data[i].size() == 0 && $urandom_range(99) < 40)
                    add_beat(i, ($urandom_range(99) < 35));
            want_rdy = ($urandom_range(99) < 70);
            want_clr = ($urandom_range(99) >= 2);
            step();
        end
        want_clr = 1'b1;
        for (int i = 0; i < NREQ; i++) add_beat(i, 1);
        drain("random");

        want_clr = 1'b0; step();
        want_clr = 1'b1; step();

`ifdef FIFO_ARB_PKT_LOCK_EN
        // Packet of three from requester 2 stays contiguous.
        add_beat(1, 1);
        drain("lock_prep1");
        add_beat(2, 0); add_beat(2, 0); add_beat(2, 1);
        add_beat(0, 1); add_beat(1, 1);
        got_ids.delete();
        drain("lock_pkt");
        exp_ids.delete();
        exp_ids.push_back(2); exp_ids.push_back(2); exp_ids.push_back(2);
        exp_ids.push_back(0); exp_ids.push_back(1);
        chk_ids("lock_pkt_order");

        // Burst cap: requester 1 is cut after MAX_BURST beats, requester 3 slips in.
        add_beat(0, 1);
        drain("lock_prep2");
        for (int b = 0; b < 10; b++) add_beat(1, 0);
        add_beat(3, 1);
        got_ids.delete();
        drain("lock_burst");
        exp_ids.delete();
        for (int b = 0; b < 4; b++) exp_ids.push_back(1);
        exp_ids.push_back(3);
        for (int b = 0; b < 6; b++) exp_ids.push_back(1);
        chk_ids("lock_burst_order");
`endif

        // Clear with a held beat (mid-lock in the lock build).
        add_beat(1, 0);
        want_rdy = 1'b0;
        step();
        add_beat(0, 1);
        want_clr = 1'b0;
        step();
        chk("clear_req_ready", dut_rdy, 4'h0);
        want_clr = 1'b1;
        want_rdy = 1'b1;
        step();
        chk("clear_wr_valid", fifo_wr_valid, 1'b0);
        chk("clear_first_grant", dut_rdy, 4'b0001);
        drain("clear");

        // Reset mid-stream.
        for (int b = 0; b < 3; b++) for (int i = 0; i < NREQ; i++) add_beat(i, 1);
        for (int c = 0; c < 6; c++) begin
            want_rdy = ($urandom_range(99) < 60);
            step();
        end
        want_rst = 1'b0;
        step();
        chk("midrst_req_ready", dut_rdy, 4'h0);
        want_rst = 1'b1;
        want_rdy = 1'b1;
        step();
        chk("midrst_wr_valid", fifo_wr_valid, 1'b0);
        chk("midrst_wr_data", fifo_wr_data, 32'h0);
        chk("midrst_grant_id", grant_id, 2'd3);
        chk("midrst_first_grant", dut_rdy, 4'b0001);
        drain("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the LED-frame FIFO between `NREQ` independent producers (host bus bridge, pattern generator, DMA-style sequencer). It selects one requester per beat, or per packet when packet locking is compiled in, and registers the winning beat into a one-entry output stage that drives the FIFO write handshake. Sits directly upstream of the FIFO; the FIFO's `wr_ready` is its only backpressure source.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `DSIZE`, 32, data width, equal to the FIFO data width
- `MAX_BURST`, 16, maximum beats granted to one requester under packet lock (1..256)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `clear_n`  in  1  synchronous clear, active-low
- `req_data`  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE]
- `req_valid`  in  NREQ  requester beat valid
- `req_last`  in  NREQ  last beat of packet (ignored without the lock feature)
- `req_ready`  out  NREQ  beat accepted from requester i this cycle
- `fifo_wr_data`  out  DSIZE  to FIFO `wr_data`
- `fifo_wr_valid`  out  1  to FIFO `wr_valid`
- `fifo_wr_ready`  in  1  from FIFO `wr_ready`
- `grant_id`  out  clog2(NREQ)  index of the last granted requester (status)

## Operation
- Output stage: one register, `out_valid`/`out_data`. `can_load = !out_valid || fifo_wr_ready`.
- Arbitration is combinational each cycle. Search starts at `(last_grant+1) mod NREQ` and wraps; the first requester with `req_valid` set wins.
- `req_ready[i] = (i == winner) && can_load`; at most one bit is set. Accepting a beat loads the output register and sets `last_grant = winner`.
- If no requester is valid and `fifo_wr_ready` is high, `out_valid` clears.
- State machine (lock feature only):
  - ARB: free arbitration. An accepted beat with `req_last=0` moves to LOCK, holding the winner with `beat_cnt=1`.
  - LOCK: only the locked requester can win. Other requesters get no ready, even if the locked requester is idle.
  - LOCK returns to ARB when an accepted beat has `req_last=1`, or when `beat_cnt` reaches `MAX_BURST`. In the forced case the pointer advances normally and the requester must re-arbitrate.
- `clear_n=0`: `out_valid<=0`, state ARB, `beat_cnt<=0`. `last_grant` is kept. `req_ready` is all-zero that cycle. `clear_n` takes priority over a simultaneous accept.
- Reset values: `out_valid=0`, `fifo_wr_data=0`, `req_ready=0`, `last_grant=NREQ-1` (requester 0 has first priority), `grant_id=NREQ-1`, state ARB, `beat_cnt=0`. A reset mid-packet discards the held beat and any lock.
- Width rules: `beat_cnt` is clog2(MAX_BURST+1) bits and saturates at `MAX_BURST`. Pointer increment wraps modulo `NREQ`; it does not rely on power-of-two wrap.

## Timing
- Latency: a beat accepted at edge N is visible on `fifo_wr_valid`/`fifo_wr_data` after edge N and is written to the FIFO at the first edge where `fifo_wr_ready=1`.
- Throughput: 1 beat/cycle while the FIFO is not full. Back-to-back beats from different requesters need no bubble.
- FIFO full (`fifo_wr_ready=0`) with `out_valid=1`: the output holds stable, all `req_ready=0`, and `last_grant`/state are frozen.
- `fifo_wr_valid` never drops while `fifo_wr_ready=0`, and `fifo_wr_data` never changes while `fifo_wr_ready=0`.
- Requesters must hold `req_valid`/`req_data` stable until `req_ready`. The combinational path from `req_valid` to `req_ready` is allowed.

## Configuration
- `FIFO_ARB_PKT_LOCK_EN` defined: the ARB/LOCK state machine, `beat_cnt` and `MAX_BURST` are active, and packets from one requester are contiguous in the FIFO.
- Not defined: arbitration happens on every beat, `req_last` and `MAX_BURST` are unused, and no lock state or counter is synthesized.

## Structure
- Package `fifo_arb_pkg` holds the ARB/LOCK state encoding and the clog2 helper function.
- Sub-module `rr_pick`: purely combinational. Inputs are the `NREQ` valid mask and the start index; outputs are a one-hot winner, the winner index and an any-valid flag. Under lock, the top level masks its input to the locked requester.

## Test plan
- Reset, NREQ=4: all four valid with distinct data → grants 0,1,2,3,0 on consecutive cycles; FIFO receives beats in that order, one per cycle.
- Hold `fifo_wr_ready=0` for 5 cycles with `out_valid=1` → `fifo_wr_data` unchanged, `req_ready=0`. Release → beat written, next grant follows rotation.
- Lock on: requester 2 sends 3 beats (last on the 3rd) while 0 and 1 are valid → FIFO shows 2,2,2 contiguous, then 0, then 1.
- Lock on, MAX_BURST=4: requester 1 streams 10 beats with `req_last=0` and requester 3 valid → 4 beats from 1, then 1 beat from 3, then 1 resumes.
- `clear_n=0` pulse mid-lock with a beat held → `fifo_wr_valid` low the next cycle, state ARB, no `req_ready` that cycle.
- `rst_n=0` mid-stream → all outputs at reset values after the edge; first post-reset grant goes to requester 0 when all are valid.
